// File: rtl/timer_count_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_count_core : 8051-style TL/TH count stage (13/16/8-bit reload)     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module timer_count_core #(
  parameter int unsigned EDGE_COUNT = 1,
  parameter logic [7:0]  TL_RST     = 8'h00,
  parameter logic [7:0]  TH_RST     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_in,
  input  logic [1:0] mode,
  input  logic       wr_tl,
  input  logic       wr_th,
  input  logic [7:0] wr_data,
  input  logic       tf_clr,
  output logic [7:0] tl,
  output logic [7:0] th,
  output logic       tf,
  output logic       ovf
);

  localparam logic [1:0] c_MODE_13   = 2'b00;
  localparam logic [1:0] c_MODE_16   = 2'b01;
  localparam logic [1:0] c_MODE_AR8  = 2'b10;
  localparam logic [1:0] c_MODE_HOLD = 2'b11;

  logic       r_cnt_q;
  logic [7:0] r_tl;
  logic [7:0] r_th;
  logic       r_tf;
  logic       r_ovf;

  logic       w_inc;
  logic       w_adv;
  logic       w_tl_carry;
  logic [7:0] w_tl_inc;
  logic       w_th_step;
  logic       w_ovf;
  logic [7:0] w_tl_nxt;
  logic [7:0] w_th_nxt;

  always_comb begin
    w_inc      = (EDGE_COUNT != 0) ? (cnt_in & ~r_cnt_q) : cnt_in;
    // A dual-byte write replaces the whole counter, so it suppresses counting.
    w_adv      = w_inc & (mode != c_MODE_HOLD) & ~(wr_tl & wr_th);
    w_tl_carry = 1'b0;
    w_tl_inc   = r_tl;
    case (mode)
      c_MODE_13: begin
        w_tl_carry = w_adv & (r_tl[4:0] == 5'h1F);
        w_tl_inc   = {r_tl[7:5], r_tl[4:0] + 5'd1};
      end
      c_MODE_16: begin
        w_tl_carry = w_adv & (r_tl == 8'hFF);
        w_tl_inc   = r_tl + 8'd1;
      end
      c_MODE_AR8: begin
        w_tl_carry = w_adv & (r_tl == 8'hFF);
        w_tl_inc   = w_tl_carry ? r_th : (r_tl + 8'd1);
      end
      default: begin
        w_tl_carry = 1'b0;
        w_tl_inc   = r_tl;
      end
    endcase

    // Carries crossing a software-written byte are dropped, and with them any overflow.
    w_th_step = w_tl_carry & ((mode == c_MODE_13) | (mode == c_MODE_16)) & ~wr_tl & ~wr_th;
    w_ovf     = (mode == c_MODE_AR8) ? (w_tl_carry & ~wr_tl)
                                     : (w_th_step & (r_th == 8'hFF));

    w_tl_nxt = wr_tl ? wr_data : (w_adv ? w_tl_inc : r_tl);
    w_th_nxt = wr_th ? wr_data : (w_th_step ? (r_th + 8'd1) : r_th);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_q <= 1'b0;
      r_tl    <= TL_RST;
      r_th    <= TH_RST;
      r_tf    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_cnt_q <= cnt_in;
      r_tl    <= w_tl_nxt;
      r_th    <= w_th_nxt;
      r_ovf   <= w_ovf;
      if (w_ovf) begin
        r_tf <= 1'b1;
      end else if (tf_clr) begin
        r_tf <= 1'b0;
      end
    end
  end

  assign tl  = r_tl;
  assign th  = r_th;
  assign tf  = r_tf;
  assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_timer_count_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_count_core : scoreboard bench, edge-count and level-count DUTs  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_timer_count_core;

  logic       clk;
  logic       rst_n;
  logic       cnt_in;
  logic [1:0] mode;
  logic       wr_tl;
  logic       wr_th;
  logic [7:0] wr_data;
  logic       tf_clr;

  logic [7:0] e_tl, e_th, l_tl, l_th;
  logic       e_tf, e_ovf, l_tf, l_ovf;

  timer_count_core #(.EDGE_COUNT(1), .TL_RST(8'h12), .TH_RST(8'h34)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .mode(mode),
    .wr_tl(wr_tl), .wr_th(wr_th), .wr_data(wr_data), .tf_clr(tf_clr),
    .tl(e_tl), .th(e_th), .tf(e_tf), .ovf(e_ovf)
  );

  timer_count_core #(.EDGE_COUNT(0), .TL_RST(8'h00), .TH_RST(8'h00)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .mode(mode),
    .wr_tl(wr_tl), .wr_th(wr_th), .wr_data(wr_data), .tf_clr(tf_clr),
    .tl(l_tl), .th(l_th), .tf(l_tf), .ovf(l_ovf)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        sel;   // 0: edge-count DUT, 1: level-count DUT
    logic [7:0]  tl;
    logic [7:0]  th;
    logic        tf;
    logic        ovf;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each queued expectation at the cycle it targets.
  always @(negedge clk) begin
    while (q_exp.size() > 0 && int'(q_exp[0].cyc) <= cyc) begin
      exp_t  e;
      string n;
      logic [7:0] a_tl, a_th;
      logic       a_tf, a_ovf;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      a_tl  = e.sel ? l_tl  : e_tl;
      a_th  = e.sel ? l_th  : e_th;
      a_tf  = e.sel ? l_tf  : e_tf;
      a_ovf = e.sel ? l_ovf : e_ovf;
      checks = checks + 1;
      if (a_tl !== e.tl || a_th !== e.th || a_tf !== e.tf || a_ovf !== e.ovf ||
          int'(e.cyc) != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: got tl=%h th=%h tf=%b ovf=%b, expected tl=%h th=%h tf=%b ovf=%b (cyc %0d/%0d)",
                 n, a_tl, a_th, a_tf, a_ovf, e.tl, e.th, e.tf, e.ovf, cyc, e.cyc);
      end
    end
  end

  task automatic step(input logic c, input logic [1:0] m, input logic wl,
                      input logic wh, input logic [7:0] d, input logic clr);
    cnt_in  = c;
    mode    = m;
    wr_tl   = wl;
    wr_th   = wh;
    wr_data = d;
    tf_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string n, input logic sel, input logic [7:0] etl,
                           input logic [7:0] eth, input logic etf, input logic eovf);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.tl  = etl;
    e.th  = eth;
    e.tf  = etf;
    e.ovf = eovf;
    q_exp.push_back(e);
    q_name.push_back(n);
  endtask

  initial begin
    rst_n = 1'b0;
    step(0, 2'b01, 0, 0, 8'h00, 0);
    step(0, 2'b01, 0, 0, 8'h00, 0);
    expect_st("reset_e", 0, 8'h12, 8'h34, 0, 0);
    expect_st("reset_l", 1, 8'h00, 8'h00, 0, 0);
    rst_n = 1'b1;

    // 16-bit wrap on the edge-count DUT
    step(0, 2'b01, 1, 0, 8'hFE, 0);
    step(0, 2'b01, 0, 1, 8'hFF, 0);
    expect_st("m16_load", 0, 8'hFE, 8'hFF, 0, 0);
    step(1, 2'b01, 0, 0, 8'h00, 0);
    expect_st("m16_ffff", 0, 8'hFF, 8'hFF, 0, 0);
    step(0, 2'b01, 0, 0, 8'h00, 0);
    step(1, 2'b01, 0, 0, 8'h00, 0);
    expect_st("m16_wrap", 0, 8'h00, 8'h00, 1, 1);
    step(0, 2'b01, 0, 0, 8'h00, 0);
    expect_st("m16_ovf_one_cycle", 0, 8'h00, 8'h00, 1, 0);

    // Level held high for 10 cycles counts once
    for (int i = 0; i < 10; i++) begin
      step(1, 2'b01, 0, 0, 8'h00, 0);
      if (i == 0) expect_st("edge_first", 0, 8'h01, 8'h00, 1, 0);
    end
    expect_st("edge_held10", 0, 8'h01, 8'h00, 1, 0);

    // Hold mode ignores counting but honours writes
    step(0, 2'b11, 0, 0, 8'h00, 0);
    step(1, 2'b11, 0, 0, 8'h00, 0);
    step(0, 2'b11, 0, 0, 8'h00, 0);
    step(1, 2'b11, 0, 0, 8'h00, 0);
    expect_st("hold_nochange", 0, 8'h01, 8'h00, 1, 0);
    step(0, 2'b11, 1, 0, 8'hAA, 0);
    expect_st("hold_write", 0, 8'hAA, 8'h00, 1, 0);

    // 13-bit mode
    step(0, 2'b00, 1, 0, 8'hFF, 1);
    step(0, 2'b00, 0, 1, 8'hFF, 0);
    expect_st("m13_load", 0, 8'hFF, 8'hFF, 0, 0);
    step(1, 2'b00, 0, 0, 8'h00, 0);
    expect_st("m13_wrap", 0, 8'hE0, 8'h00, 1, 1);
    step(0, 2'b00, 1, 0, 8'h3F, 0);
    step(0, 2'b00, 0, 1, 8'h05, 0);
    step(1, 2'b00, 0, 0, 8'h00, 0);
    expect_st("m13_carry", 0, 8'h20, 8'h06, 1, 0);

    // Writes colliding with increments
    step(0, 2'b01, 1, 0, 8'hFF, 0);
    step(0, 2'b01, 0, 1, 8'hFF, 0);
    step(1, 2'b01, 1, 0, 8'h55, 1);
    expect_st("wr_tl_drop_carry", 0, 8'h55, 8'hFF, 0, 0);
    step(0, 2'b01, 1, 0, 8'hFF, 0);
    step(1, 2'b01, 0, 0, 8'h00, 1);
    expect_st("ovf_beats_clr", 0, 8'h00, 8'h00, 1, 1);
    step(0, 2'b01, 1, 0, 8'hFF, 0);
    step(0, 2'b01, 0, 1, 8'hFF, 0);
    step(1, 2'b01, 0, 1, 8'h77, 0);
    expect_st("wr_th_drop_carry", 0, 8'h00, 8'h77, 1, 0);
    step(0, 2'b01, 0, 0, 8'h00, 0);
    step(1, 2'b01, 1, 1, 8'h33, 0);
    expect_st("wr_both_noinc", 0, 8'h33, 8'h33, 1, 0);

    // Reset mid-count
    step(0, 2'b01, 1, 0, 8'h7A, 0);
    rst_n = 1'b0;
    step(1, 2'b01, 0, 0, 8'h00, 0);
    expect_st("reset_mid", 0, 8'h12, 8'h34, 0, 0);
    rst_n = 1'b1;
    step(0, 2'b01, 0, 0, 8'h00, 0);
    step(1, 2'b01, 0, 0, 8'h00, 0);
    expect_st("post_reset_inc", 0, 8'h13, 8'h34, 0, 0);
    step(1, 2'b01, 0, 0, 8'h00, 0);
    expect_st("post_reset_held", 0, 8'h13, 8'h34, 0, 0);

    // 8-bit auto-reload on the level-count DUT
    step(0, 2'b10, 0, 1, 8'hF0, 1);
    step(0, 2'b10, 1, 0, 8'hFE, 0);
    expect_st("ar8_load", 1, 8'hFE, 8'hF0, 0, 0);
    step(1, 2'b10, 0, 0, 8'h00, 0);
    expect_st("ar8_ff", 1, 8'hFF, 8'hF0, 0, 0);
    step(1, 2'b10, 0, 0, 8'h00, 0);
    expect_st("ar8_reload", 1, 8'hF0, 8'hF0, 1, 1);
    step(1, 2'b10, 0, 0, 8'h00, 0);
    expect_st("ar8_f1", 1, 8'hF1, 8'hF0, 1, 0);
    step(1, 2'b10, 0, 0, 8'h00, 0);
    expect_st("ar8_f2", 1, 8'hF2, 8'hF0, 1, 0);

    step(0, 2'b11, 0, 0, 8'h00, 0);
    step(0, 2'b11, 0, 0, 8'h00, 0);
    checks = checks + 1;
    if (q_exp.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
